// File: rtl/tile_scan_reader.sv
// Tile-order frame reader: issues BRAM reads tile by tile, realigns returning data behind the
// fixed read latency and streams pixels through a credit-managed FIFO. Optional macro: TILE_SCAN_RASTER_MODE_EN.
module tile_scan_reader #(
  parameter int RAM_WIDTH   = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int RD_LATENCY  = 2,
  parameter int ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  output logic                 oRdEn,
  output logic [ADDR_W-1:0]    oRdAddr,
  input  logic [RAM_WIDTH-1:0] iRdData,
  output logic [RAM_WIDTH-1:0] oData,
  output logic                 oValid,
  input  logic                 iReady,
`ifdef TILE_SCAN_RASTER_MODE_EN
  input  logic                 iRaster,
`endif
  output logic                 oTileLast,
  output logic                 oFrameLast,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam int DEPTH   = RD_LATENCY + 2;
  localparam int TILES_X = IMG_WIDTH / TILE_WIDTH;
  localparam int TILES_Y = IMG_HEIGHT / TILE_HEIGHT;
  localparam int XW  = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
  localparam int YW  = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int CW  = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int RW  = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int NW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(RD_LATENCY + DEPTH + 1);
  localparam int EW  = RAM_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CW-1:0]         tc_q, tc_d;
  logic [RW-1:0]         tr_q, tr_d;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_t_q, tag_t_d, tag_f_q, tag_f_d;
  logic [EW-1:0]         fifo_q [DEPTH];
  logic [EW-1:0]         fifo_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         cnt_q, cnt_d;

  logic                  x_last, y_last, tc_last, tr_last;
  logic                  tile_last, frame_last, rd_en, push, pop;
  logic [ADDR_W-1:0]     addr;
  logic [OW-1:0]         occ;
  logic [EW-1:0]         head;

`ifdef TILE_SCAN_RASTER_MODE_EN
  localparam int IXW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int IYW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  logic [IXW-1:0] rx_q, rx_d;
  logic [IYW-1:0] ry_q, ry_d;
  logic           raster_q, raster_d;
  logic           rx_last, ry_last;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    tc_d     = tc_q;
    tr_d     = tr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_d   = fifo_q;
    tag_v_d  = '0;
    tag_t_d  = '0;
    tag_f_d  = '0;

    x_last     = (x_q == XW'(TILE_WIDTH - 1));
    y_last     = (y_q == YW'(TILE_HEIGHT - 1));
    tc_last    = (tc_q == CW'(TILES_X - 1));
    tr_last    = (tr_q == RW'(TILES_Y - 1));
    tile_last  = x_last && y_last;
    frame_last = tile_last && tc_last && tr_last;
    addr = (ADDR_W'(tr_q) * ADDR_W'(TILE_HEIGHT) + ADDR_W'(y_q)) * ADDR_W'(IMG_WIDTH)
         + ADDR_W'(tc_q) * ADDR_W'(TILE_WIDTH) + ADDR_W'(x_q);
`ifdef TILE_SCAN_RASTER_MODE_EN
    rx_d     = rx_q;
    ry_d     = ry_q;
    raster_d = raster_q;
    rx_last  = (rx_q == IXW'(IMG_WIDTH - 1));
    ry_last  = (ry_q == IYW'(IMG_HEIGHT - 1));
    if (raster_q) begin
      tile_last  = rx_last;
      frame_last = rx_last && ry_last;
      addr       = ADDR_W'(ry_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(rx_q);
    end
`endif

    // Credits cover every read whose data could still land in the FIFO.
    occ = OW'(cnt_q);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + OW'(tag_v_q[i]);
    rd_en = (state_q == S_RUN) && (occ < OW'(DEPTH));
    push  = tag_v_q[RD_LATENCY-1];
    pop   = (cnt_q != '0) && iReady;
    head  = fifo_q[rd_ptr_q];

    tag_v_d[0] = rd_en;
    tag_t_d[0] = rd_en && tile_last;
    tag_f_d[0] = rd_en && frame_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_t_d[i] = tag_t_q[i-1];
      tag_f_d[i] = tag_f_q[i-1];
    end

    if (push) begin
      fifo_d[wr_ptr_q] = {tag_f_q[RD_LATENCY-1], tag_t_q[RD_LATENCY-1], iRdData};
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    cnt_d = cnt_q + NW'(push) - NW'(pop);

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_RUN;
          x_d  = '0;
          y_d  = '0;
          tc_d = '0;
          tr_d = '0;
`ifdef TILE_SCAN_RASTER_MODE_EN
          raster_d = iRaster;
          rx_d     = '0;
          ry_d     = '0;
`endif
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (frame_last) state_d = S_DRAIN;
`ifdef TILE_SCAN_RASTER_MODE_EN
          if (raster_q) begin
            rx_d = rx_last ? '0 : rx_q + IXW'(1);
            if (rx_last) ry_d = ry_last ? '0 : ry_q + IYW'(1);
          end else begin
`endif
            x_d = x_last ? '0 : x_q + XW'(1);
            if (x_last) begin
              y_d = y_last ? '0 : y_q + YW'(1);
              if (y_last) begin
                tc_d = tc_last ? '0 : tc_q + CW'(1);
                if (tc_last) tr_d = tr_last ? '0 : tr_q + RW'(1);
              end
            end
`ifdef TILE_SCAN_RASTER_MODE_EN
          end
`endif
        end
      end
      S_DRAIN: if (pop && head[EW-1]) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tc_q     <= '0;
      tr_q     <= '0;
      tag_v_q  <= '0;
      tag_t_q  <= '0;
      tag_f_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef TILE_SCAN_RASTER_MODE_EN
      rx_q     <= '0;
      ry_q     <= '0;
      raster_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tc_q     <= tc_d;
      tr_q     <= tr_d;
      tag_v_q  <= tag_v_d;
      tag_t_q  <= tag_t_d;
      tag_f_q  <= tag_f_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef TILE_SCAN_RASTER_MODE_EN
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      raster_q <= raster_d;
`endif
    end
  end

  // Storage needs no reset: an empty count masks every entry.
  always_ff @(posedge iClk) fifo_q <= fifo_d;

  assign oRdEn      = rd_en;
  assign oRdAddr    = rd_en ? addr : '0;
  assign oValid     = (cnt_q != '0);
  assign oData      = oValid ? head[RAM_WIDTH-1:0] : '0;
  assign oTileLast  = oValid && head[RAM_WIDTH];
  assign oFrameLast = oValid && head[RAM_WIDTH+1];
  assign oBusy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign oDone      = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_scan_reader.sv
// Bench for tile_scan_reader on a 32x16 frame of 16x16 tiles: BRAM model with addr-derived data and
// a scoreboard of expected addresses and {frameLast, tileLast, data} filled whenever a frame is started.
module tb_tile_scan_reader;
  localparam int IW = 32;
  localparam int IH = 16;
  localparam int TW = 16;
  localparam int TH = 16;
  localparam int NPIX = IW * IH;

  logic       iClk = 1'b0;
  logic       iRst, iStart, iReady;
  logic       oRdEn, oValid, oTileLast, oFrameLast, oBusy, oDone;
  logic [8:0] oRdAddr;
  logic [7:0] iRdData, oData;
`ifdef TILE_SCAN_RASTER_MODE_EN
  logic       iRaster;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] exp_q [$];
  logic [8:0] addr_q [$];

  tile_scan_reader #(
    .RAM_WIDTH(8), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TILE_WIDTH(TW),
    .TILE_HEIGHT(TH), .RD_LATENCY(2), .ADDR_W(9)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oRdEn(oRdEn), .oRdAddr(oRdAddr),
    .iRdData(iRdData), .oData(oData), .oValid(oValid), .iReady(iReady),
`ifdef TILE_SCAN_RASTER_MODE_EN
    .iRaster(iRaster),
`endif
    .oTileLast(oTileLast), .oFrameLast(oFrameLast), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  // Two-stage BRAM read pipeline: data appears two cycles after the enable.
  logic [7:0] mem [NPIX];
  logic [7:0] p1 = '0, p2 = '0;
  initial for (int a = 0; a < NPIX; a++) mem[a] = 8'(a);
  always @(posedge iClk) begin
    if (oRdEn) p1 <= mem[oRdAddr];
    p2 <= p1;
  end
  assign iRdData = p2;

  function automatic void push_frame(input bit raster);
    int a;
    bit tl, fl;
    if (raster) begin
      for (int p = 0; p < NPIX; p++) begin
        tl = ((p % IW) == IW - 1);
        fl = (p == NPIX - 1);
        addr_q.push_back(9'(p));
        exp_q.push_back({fl, tl, 8'(p)});
      end
    end else begin
      for (int tr = 0; tr < IH / TH; tr++)
        for (int tc = 0; tc < IW / TW; tc++)
          for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
              a  = (tr * TH + y) * IW + tc * TW + x;
              tl = (x == TW - 1) && (y == TH - 1);
              fl = tl && (tc == IW / TW - 1) && (tr == IH / TH - 1);
              addr_q.push_back(9'(a));
              exp_q.push_back({fl, tl, 8'(a)});
            end
    end
  endfunction

  task automatic test_reset();
    iRst = 1'b0; iStart = 1'b0; iReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) iRst = 1'b1;
      @(negedge iClk);
      checks++;
      if ({oRdEn, oRdAddr, oData, oValid, oTileLast, oFrameLast, oBusy, oDone} !== 24'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h expected 000000", {oRdEn, oRdAddr, oData, oValid, oTileLast, oFrameLast, oBusy, oDone});
      end
      @(posedge iClk); #1; cyc++;
    end
  endtask

  task automatic test_tile_order();
    int t0, first_rd, first_val, n, last_cyc, done_cyc;
    logic [9:0] e;
    logic [8:0] ea;
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iReady = 1'b1; iStart = 1'b1;
    t0 = cyc; first_rd = -1; first_val = -1; n = 0; last_cyc = -1; done_cyc = -1;
    for (int k = 0; k < 1500 && done_cyc < 0; k++) begin
      @(negedge iClk);
      if (oRdEn) begin
        if (first_rd < 0) first_rd = cyc;
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("[TB] FAIL tile_addr: got extra read at %0d expected none", oRdAddr);
        end else begin
          ea = addr_q.pop_front();
          if (oRdAddr !== ea) begin errors++; $display("[TB] FAIL tile_addr: got %0d expected %0d", oRdAddr, ea); end
        end
      end
      if (oValid && first_val < 0) first_val = cyc;
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL tile_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL tile_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        if (oFrameLast) last_cyc = cyc;
        n++;
      end
      if (oDone) done_cyc = cyc;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
    end
    checks++;
    if (first_rd != t0 + 1) begin errors++; $display("[TB] FAIL first_rden_latency: got %0d expected 1", first_rd - t0); end
    checks++;
    if (first_val != t0 + 4) begin errors++; $display("[TB] FAIL first_valid_latency: got %0d expected 4", first_val - t0); end
    checks++;
    if (n != NPIX) begin errors++; $display("[TB] FAIL tile_count: got %0d expected %0d", n, NPIX); end
    checks++;
    if (done_cyc < 0 || done_cyc != last_cyc + 1) begin
      errors++; $display("[TB] FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    int n, issued, done_cyc;
    logic [9:0] e, held;
    logic stalled;
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iReady = 1'b1; iStart = 1'b1;
    n = 0; issued = 0; done_cyc = -1; stalled = 1'b0; held = '0;
    for (int k = 0; k < 4000 && done_cyc < 0; k++) begin
      @(negedge iClk);
      if (stalled) begin
        checks++;
        if ({oValid, oFrameLast, oTileLast, oData} !== {1'b1, held}) begin
          errors++; $display("[TB] FAIL stall_hold: got %h expected %h", {oValid, oFrameLast, oTileLast, oData}, {1'b1, held});
        end
      end
      if (oRdEn) begin
        issued++;
        checks++;
        if (issued - n > 4) begin errors++; $display("[TB] FAIL credit_bound: got %0d outstanding expected <= 4", issued - n); end
      end
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL bp_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL bp_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        n++;
      end
      stalled = oValid && !iReady;
      held = {oFrameLast, oTileLast, oData};
      if (oDone) done_cyc = cyc;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
      iReady = 1'($urandom_range(0, 1));
    end
    checks++;
    if (n != NPIX || done_cyc < 0) begin
      errors++; $display("[TB] FAIL bp_count: got %0d transfers done=%0d expected %0d done", n, done_cyc >= 0, NPIX);
    end
  endtask

  task automatic test_stall();
    int n, issued, first_val, done_cyc;
    logic [9:0] e;
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iReady = 1'b0; iStart = 1'b1;
    n = 0; issued = 0; first_val = -1; done_cyc = -1;
    for (int k = 0; k < 1500 && done_cyc < 0; k++) begin
      @(negedge iClk);
      if (oRdEn) issued++;
      if (oValid && first_val < 0) first_val = cyc;
      if (first_val >= 0 && cyc == first_val + 19) begin
        checks++;
        if (issued > 4 || issued == 0) begin errors++; $display("[TB] FAIL stall_reads: got %0d expected 1..4", issued); end
        checks++;
        if ({oValid, oFrameLast, oTileLast, oData} !== {1'b1, exp_q[0]}) begin
          errors++; $display("[TB] FAIL stall_head: got %h expected %h", {oValid, oFrameLast, oTileLast, oData}, {1'b1, exp_q[0]});
        end
      end
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL stall_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL stall_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        n++;
      end
      if (oDone) done_cyc = cyc;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
      if (first_val >= 0 && cyc >= first_val + 20) iReady = 1'b1;
    end
    checks++;
    if (n != NPIX || done_cyc < 0) begin
      errors++; $display("[TB] FAIL stall_count: got %0d transfers done=%0d expected %0d done", n, done_cyc >= 0, NPIX);
    end
  endtask

  task automatic test_reset_midframe();
    int n, done_cyc;
    logic [9:0] e;
    logic [8:0] ea;
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iReady = 1'b1; iStart = 1'b1; n = 0;
    for (int k = 0; k < 400 && n < 100; k++) begin
      @(negedge iClk);
      if (oValid && iReady) n++;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
    end
    checks++;
    if (n != 100) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 100", n); end
    iRst = 1'b0;
    @(posedge iClk); #1; cyc++;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) iRst = 1'b1;
      @(negedge iClk);
      checks++;
      if ({oRdEn, oRdAddr, oData, oValid, oTileLast, oFrameLast, oBusy, oDone} !== 24'h0) begin
        errors++;
        $display("[TB] FAIL abort_outputs: got %h expected 000000", {oRdEn, oRdAddr, oData, oValid, oTileLast, oFrameLast, oBusy, oDone});
      end
      @(posedge iClk); #1; cyc++;
    end
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iStart = 1'b1; n = 0; done_cyc = -1;
    for (int k = 0; k < 1500 && done_cyc < 0; k++) begin
      @(negedge iClk);
      if (oRdEn) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("[TB] FAIL restart_addr: got extra read at %0d expected none", oRdAddr);
        end else begin
          ea = addr_q.pop_front();
          if (oRdAddr !== ea) begin errors++; $display("[TB] FAIL restart_addr: got %0d expected %0d", oRdAddr, ea); end
        end
      end
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL restart_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL restart_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        n++;
      end
      if (oDone) done_cyc = cyc;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
    end
    checks++;
    if (n != NPIX || done_cyc < 0) begin
      errors++; $display("[TB] FAIL restart_count: got %0d transfers done=%0d expected %0d done", n, done_cyc >= 0, NPIX);
    end
  endtask

  task automatic test_start_ignore();
    int n, dones, t0, fl_cyc, done1, s2, rd_after;
    logic [9:0] e;
    logic [8:0] ea;
    exp_q.delete(); addr_q.delete(); push_frame(1'b0);
    iReady = 1'b1; iStart = 1'b1;
    t0 = cyc; n = 0; dones = 0; fl_cyc = -10; done1 = -10; s2 = -10; rd_after = -1;
    for (int k = 0; k < 2500 && dones < 2; k++) begin
      @(negedge iClk);
      if (oRdEn) begin
        if (dones == 1 && rd_after < 0) rd_after = cyc;
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("[TB] FAIL ign_addr: got extra read at %0d expected none", oRdAddr);
        end else begin
          ea = addr_q.pop_front();
          if (oRdAddr !== ea) begin errors++; $display("[TB] FAIL ign_addr: got %0d expected %0d", oRdAddr, ea); end
        end
      end
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL ign_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL ign_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        if (oFrameLast) fl_cyc = cyc;
        n++;
      end
      if (oDone) begin
        dones++;
        if (dones == 1) done1 = cyc;
        checks++;
        if (cyc != fl_cyc + 1) begin errors++; $display("[TB] FAIL ign_done: got cycle %0d expected %0d", cyc, fl_cyc + 1); end
      end
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0;
      // Pulses in RUN and in DONE must be ignored; the one right after DONE starts frame two.
      if (cyc == t0 + 10) iStart = 1'b1;
      if (dones == 0 && cyc == fl_cyc + 1) iStart = 1'b1;
      if (dones == 1 && cyc == done1 + 1) begin
        iStart = 1'b1; s2 = cyc; push_frame(1'b0);
      end
    end
    checks++;
    if (dones != 2 || n != 2 * NPIX) begin
      errors++; $display("[TB] FAIL ign_frames: got %0d dones %0d transfers expected 2 dones %0d transfers", dones, n, 2 * NPIX);
    end
    checks++;
    if (rd_after != s2 + 1) begin errors++; $display("[TB] FAIL second_start: got first read cycle %0d expected %0d", rd_after, s2 + 1); end
    for (int k = 0; k < 8; k++) begin
      @(negedge iClk);
      checks++;
      if ({oBusy, oRdEn, oValid} !== 3'b000) begin
        errors++; $display("[TB] FAIL idle_after: got %b expected 000", {oBusy, oRdEn, oValid});
      end
      @(posedge iClk); #1; cyc++;
    end
  endtask

`ifdef TILE_SCAN_RASTER_MODE_EN
  task automatic test_raster();
    int n, done_cyc;
    logic [9:0] e;
    logic [8:0] ea;
    exp_q.delete(); addr_q.delete(); push_frame(1'b1);
    iReady = 1'b1; iRaster = 1'b1; iStart = 1'b1; n = 0; done_cyc = -1;
    for (int k = 0; k < 1500 && done_cyc < 0; k++) begin
      @(negedge iClk);
      if (oRdEn) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("[TB] FAIL raster_addr: got extra read at %0d expected none", oRdAddr);
        end else begin
          ea = addr_q.pop_front();
          if (oRdAddr !== ea) begin errors++; $display("[TB] FAIL raster_addr: got %0d expected %0d", oRdAddr, ea); end
        end
      end
      if (oValid && iReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL raster_data: got extra transfer %h expected none", oData);
        end else begin
          e = exp_q.pop_front();
          if ({oFrameLast, oTileLast, oData} !== e) begin
            errors++; $display("[TB] FAIL raster_data #%0d: got %h expected %h", n, {oFrameLast, oTileLast, oData}, e);
          end
        end
        n++;
      end
      if (oDone) done_cyc = cyc;
      @(posedge iClk); #1; cyc++;
      iStart = 1'b0; iRaster = 1'b0;
    end
    checks++;
    if (n != NPIX || done_cyc < 0) begin
      errors++; $display("[TB] FAIL raster_count: got %0d transfers done=%0d expected %0d done", n, done_cyc >= 0, NPIX);
    end
  endtask
`endif

  initial begin
    iRst = 1'b0; iStart = 1'b0; iReady = 1'b0;
`ifdef TILE_SCAN_RASTER_MODE_EN
    iRaster = 1'b0;
`endif
    @(posedge iClk); #1; cyc++;
    test_reset();
    test_tile_order();
    test_backpressure();
    test_stall();
    test_reset_midframe();
    test_start_ignore();
`ifdef TILE_SCAN_RASTER_MODE_EN
    test_raster();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
